// File: rtl/trap_ctrl_mc.sv
// Machine-mode trap controller: synchronised IRQ lines + timer + exceptions -> mepc/mcause/mtval/mstatus, redirect pulse.
// Latency: ext_irq->mip_ext SYNC_STAGES+1 cycles; candidate->trap 1 cycle; trap lasts exactly 1 cycle.
// Backpressure: none; trap/vector_addr are a one-shot redirect and must be consumed. Optional edge lines: TRAP_CTRL_EDGE_EN.
module trap_ctrl_mc #(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic [NUM_IRQ-1:0]    ext_irq,
  input  logic [NUM_IRQ-1:0]    irq_en,
  input  logic [NUM_IRQ-1:0]    irq_edge_sel,
  input  logic                  timer_int,
  input  logic                  mtie,
  input  logic                  exc_valid,
  input  logic [3:0]            exc_code,
  input  logic [DATA_WIDTH-1:0] exc_tval,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic [ADDR_WIDTH-1:0] int_pc,
  input  logic                  mret,
  input  logic                  csr_wr,
  input  logic [2:0]            csr_sel,
  input  logic [1:0]            csr_op,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [1:0]            mtvec_mode,
  input  logic [ADDR_WIDTH-1:0] mtvec_base,
  output logic                  trap,
  output logic [ADDR_WIDTH-1:0] vector_addr,
  output logic [ADDR_WIDTH-1:0] mepc,
  output logic [DATA_WIDTH-1:0] mcause,
  output logic [DATA_WIDTH-1:0] mtval,
  output logic                  mstatus_mie,
  output logic                  mstatus_mpie,
  output logic [NUM_IRQ-1:0]    mip_ext,
  output logic                  mip_t
);

  typedef enum logic {S_IDLE, S_TRAP} state_t;

  localparam logic [2:0] SEL_MEPC    = 3'd0;
  localparam logic [2:0] SEL_MCAUSE  = 3'd1;
  localparam logic [2:0] SEL_MTVAL   = 3'd2;
  localparam logic [2:0] SEL_MSTATUS = 3'd3;

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0]    sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0]    sync_out;
  logic [NUM_IRQ-1:0]    mip_ext_d;
  logic [NUM_IRQ-1:0]    int_req;
  logic                  tmr_req;
  logic                  take_exc, take_tmr, take_ext, entry;
  logic [4:0]            ext_idx;
  logic [4:0]            entry_code;
  logic [DATA_WIDTH-1:0] entry_cause;
  logic [ADDR_WIDTH-1:0] entry_vec;
  logic [ADDR_WIDTH-1:0] vec_off;
  logic [DATA_WIDTH-1:0] mstatus_word, mstatus_new;
  logic [ADDR_WIDTH-1:0] mepc_csr;
  logic [DATA_WIDTH-1:0] mcause_csr, mtval_csr;

  // write = replace, set = OR, clear = AND-NOT; reserved op leaves the value alone
  function automatic logic [DATA_WIDTH-1:0] csr_apply(input logic [DATA_WIDTH-1:0] old,
                                                      input logic [DATA_WIDTH-1:0] wd,
                                                      input logic [1:0]            op);
    case (op)
      2'd0:    csr_apply = wd;
      2'd1:    csr_apply = old | wd;
      2'd2:    csr_apply = old & ~wd;
      default: csr_apply = old;
    endcase
  endfunction

  // multi-flop synchroniser per external line
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= ext_irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // request qualification from registered pending bits
  assign int_req = mip_ext & irq_en & {NUM_IRQ{mstatus_mie}};
  assign tmr_req = mip_t & mtie & mstatus_mie;

  // trap-entry FSM next state and fixed-priority arbitration (exc > timer > line 0 .. N-1)
  always_comb begin
    state_d  = state_q;
    take_exc = 1'b0;
    take_tmr = 1'b0;
    take_ext = 1'b0;
    ext_idx  = '0;
    for (int k = NUM_IRQ-1; k >= 0; k--) begin
      if (int_req[k]) ext_idx = 5'(k);
    end
    case (state_q)
      S_IDLE: begin
        if (exc_valid)     take_exc = 1'b1;
        else if (tmr_req)  take_tmr = 1'b1;
        else if (|int_req) take_ext = 1'b1;
        if (take_exc || take_tmr || take_ext) state_d = S_TRAP;
      end
      S_TRAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign entry = take_exc | take_tmr | take_ext;

  // cause code and redirect target computed for the entry edge
  always_comb begin
    entry_code = take_tmr ? 5'd7 : (5'd16 + ext_idx);
    vec_off    = {{(ADDR_WIDTH-7){1'b0}}, entry_code, 2'b00};
    if (take_exc) entry_cause = {{(DATA_WIDTH-4){1'b0}}, exc_code};
    else          entry_cause = {1'b1, {(DATA_WIDTH-6){1'b0}}, entry_code};
    if (take_exc || (mtvec_mode != 2'b01)) entry_vec = mtvec_base;
    else                                   entry_vec = mtvec_base + vec_off;
  end

  // software CSR update values (only applied when no hardware entry on this edge)
  always_comb begin
    mstatus_word    = '0;
    mstatus_word[3] = mstatus_mie;
    mstatus_word[7] = mstatus_mpie;
    mstatus_new     = csr_apply(mstatus_word, csr_wdata, csr_op);
    mepc_csr        = ADDR_WIDTH'(csr_apply(DATA_WIDTH'(mepc), csr_wdata, csr_op));
    mcause_csr      = csr_apply(mcause, csr_wdata, csr_op);
    mtval_csr       = csr_apply(mtval, csr_wdata, csr_op);
  end

  // FSM state register
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign trap = (state_q == S_TRAP);

  // trap CSRs: hardware entry beats mret and software writes on the same edge
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      mepc         <= '0;
      mcause       <= '1;
      mtval        <= '0;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      vector_addr  <= '0;
    end else if (entry) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mepc         <= take_exc ? exc_pc : int_pc;
      mcause       <= entry_cause;
      mtval        <= take_exc ? exc_tval : '0;
      vector_addr  <= entry_vec;
    end else begin
      if (mret && (state_q == S_IDLE)) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_wr && (csr_sel == SEL_MSTATUS)) begin
        mstatus_mie  <= mstatus_new[3];
        mstatus_mpie <= mstatus_new[7];
      end
      if (csr_wr && (csr_sel == SEL_MEPC))   mepc   <= mepc_csr;
      if (csr_wr && (csr_sel == SEL_MCAUSE)) mcause <= mcause_csr;
      if (csr_wr && (csr_sel == SEL_MTVAL))  mtval  <= mtval_csr;
    end
  end

`ifdef TRAP_CTRL_EDGE_EN
  localparam logic [2:0] SEL_MIP = 3'd4;

  logic [NUM_IRQ-1:0] sync_prev;
  logic [NUM_IRQ-1:0] ext_hit;
  logic               csr_bit;

  // edge lines keep a sticky pending bit (mip bit 16+k); level lines just follow the synchroniser
  always_comb begin
    mip_ext_d = '0;
    ext_hit   = '0;
    csr_bit   = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      ext_hit[k] = take_ext && (ext_idx == 5'(k));
      if (irq_edge_sel[k]) begin
        mip_ext_d[k] = mip_ext[k];
        if (csr_wr && (csr_sel == SEL_MIP)) begin
          csr_bit = csr_wdata[16+k];
          case (csr_op)
            2'd0:    mip_ext_d[k] = csr_bit;
            2'd1:    mip_ext_d[k] = mip_ext[k] | csr_bit;
            2'd2:    mip_ext_d[k] = mip_ext[k] & ~csr_bit;
            default: mip_ext_d[k] = mip_ext[k];
          endcase
        end
        if (ext_hit[k])                   mip_ext_d[k] = 1'b0;
        if (sync_out[k] && !sync_prev[k]) mip_ext_d[k] = 1'b1;
      end else begin
        mip_ext_d[k] = sync_out[k];
      end
    end
  end

  // previous synchroniser output for rising-edge detection
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) sync_prev <= '0;
    else         sync_prev <= sync_out;
  end
`else
  logic unused_edge_sel;

  // every line is level-sensitive; mip software writes have no effect
  always_comb begin
    mip_ext_d = sync_out;
  end

  assign unused_edge_sel = ^irq_edge_sel;
`endif

  // pending registers
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      mip_ext <= '0;
      mip_t   <= 1'b0;
    end else begin
      mip_ext <= mip_ext_d;
      mip_t   <= timer_int;
    end
  end

endmodule

// File: tb/tb_trap_ctrl_mc.sv
module tb_trap_ctrl_mc;
  localparam int NI = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic [NI-1:0] ext_irq, irq_en, irq_edge_sel;
  logic          timer_int, mtie, exc_valid, mret, csr_wr;
  logic [3:0]    exc_code;
  logic [DW-1:0] exc_tval, csr_wdata, mcause, mtval;
  logic [AW-1:0] exc_pc, int_pc, mtvec_base, vector_addr, mepc;
  logic [2:0]    csr_sel;
  logic [1:0]    csr_op, mtvec_mode;
  logic          trap, mstatus_mie, mstatus_mpie, mip_t;
  logic [NI-1:0] mip_ext;

  int checks = 0;
  int failures = 0;

  trap_ctrl_mc #(.NUM_IRQ(NI), .SYNC_STAGES(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .ext_irq(ext_irq), .irq_en(irq_en),
    .irq_edge_sel(irq_edge_sel), .timer_int(timer_int), .mtie(mtie), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_tval(exc_tval), .exc_pc(exc_pc), .int_pc(int_pc), .mret(mret),
    .csr_wr(csr_wr), .csr_sel(csr_sel), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .mtvec_mode(mtvec_mode), .mtvec_base(mtvec_base), .trap(trap), .vector_addr(vector_addr),
    .mepc(mepc), .mcause(mcause), .mtval(mtval), .mstatus_mie(mstatus_mie),
    .mstatus_mpie(mstatus_mpie), .mip_ext(mip_ext), .mip_t(mip_t)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // advance n clock edges, leaving time 1 unit past the last edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cpu_clk);
      #1;
    end
  endtask

  task automatic csr(input logic [2:0] sel, input logic [1:0] op, input logic [31:0] wd);
    csr_wr = 1'b1; csr_sel = sel; csr_op = op; csr_wdata = wd;
    tick(1);
    csr_wr = 1'b0;
  endtask

  initial begin
    cpu_rst = 1'b1; ext_irq = '0; irq_en = '0; irq_edge_sel = '0; timer_int = 1'b0;
    mtie = 1'b0; exc_valid = 1'b0; exc_code = '0; exc_tval = 32'hDEAD; exc_pc = 32'h2000;
    int_pc = 32'h1000; mret = 1'b0; csr_wr = 1'b0; csr_sel = '0; csr_op = '0; csr_wdata = '0;
    mtvec_mode = 2'b00; mtvec_base = 32'h200;
    tick(3);
    cpu_rst = 1'b0;
    tick(1);
    check("rst_trap", trap, 0);
    check("rst_mcause", mcause, 32'hFFFF_FFFF);
    check("rst_mepc", mepc, 0);
    check("rst_mtval", mtval, 0);
    check("rst_mie", mstatus_mie, 0);
    check("rst_mpie", mstatus_mpie, 0);
    check("rst_vec", vector_addr, 0);
    check("rst_mip", {mip_t, mip_ext}, 0);

    // enable global interrupts
    csr(3'd3, 2'd1, 32'h8);
    check("csr_set_mie", {mstatus_mpie, mstatus_mie}, 2'b01);

    // T1: level line 2
    irq_en = 4'b0100;
    ext_irq = 4'b0100;
    tick(2);
    check("t1_mip_early", mip_ext, 4'b0000);
    tick(1);
    check("t1_mip_c3", mip_ext, 4'b0100);
    check("t1_no_trap_c3", trap, 0);
    tick(1);
    check("t1_trap_c4", trap, 1);
    check("t1_mcause", mcause, 32'h8000_0012);
    check("t1_mepc", mepc, 32'h1000);
    check("t1_mtval", mtval, 0);
    check("t1_mie_mpie", {mstatus_mpie, mstatus_mie}, 2'b10);
    check("t1_vec_direct", vector_addr, 32'h200);
    tick(1);
    check("t1_trap_pulse", trap, 0);
    tick(2);
    check("t1_masked", trap, 0);

    // T4: mret re-enables, level line still high -> second trap 2 cycles after mret
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    check("t4_mret_stack", {mstatus_mpie, mstatus_mie}, 2'b11);
    check("t4_no_trap_yet", trap, 0);
    tick(1);
    check("t4_retrap", trap, 1);
    check("t4_retrap_mcause", mcause, 32'h8000_0012);
    tick(1);
    ext_irq = '0;
    tick(4);
    check("t4_mip_drained", mip_ext, 0);

    // T2: exception beats pending timer and line 0, even in vectored mode
    irq_en = 4'b0001; mtie = 1'b1; timer_int = 1'b1; ext_irq = 4'b0001; mtvec_mode = 2'b01;
    tick(4);
    check("t2_pending", {mip_t, mip_ext}, 5'b10001);
    csr(3'd3, 2'd1, 32'h8);
    exc_valid = 1'b1; exc_code = 4'd2;
    tick(1);
    exc_valid = 1'b0;
    check("t2_trap", trap, 1);
    check("t2_mcause", mcause, 32'h2);
    check("t2_mtval", mtval, 32'hDEAD);
    check("t2_mepc", mepc, 32'h2000);
    check("t2_vec_base", vector_addr, 32'h200);
    tick(1);

    // T3: vectored timer
    irq_en = '0; mtvec_base = 32'h100;
    csr(3'd3, 2'd1, 32'h8);
    tick(1);
    check("t3_trap", trap, 1);
    check("t3_vec", vector_addr, 32'h11C);
    check("t3_mcause", mcause, 32'h8000_0007);
    check("t3_mepc", mepc, 32'h1000);
    timer_int = 1'b0; ext_irq = '0; mtie = 1'b0;
    tick(4);

    // T5: exception entry beats same-edge mepc write; nested exception with mie=0
    exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h3000;
    csr(3'd0, 2'd0, 32'h40);
    exc_valid = 1'b0;
    check("t5_trap_mie0", trap, 1);
    check("t5_mepc_hw_wins", mepc, 32'h3000);
    tick(1);
    csr(3'd0, 2'd1, 32'h3);
    check("t5_mepc_set", mepc, 32'h3003);
    csr(3'd0, 2'd2, 32'h1);
    check("t5_mepc_clear", mepc, 32'h3002);
    csr(3'd1, 2'd0, 32'h55);
    check("t5_mcause_wr", mcause, 32'h55);
    csr(3'd4, 2'd1, 32'h0002_0000);
    check("t5_mip_level_ignores_csr", mip_ext, 0);

`ifdef TRAP_CTRL_EDGE_EN
    // T6: edge line 1 is sticky, cleared on entry
    irq_edge_sel = 4'b0010; irq_en = 4'b0010;
    ext_irq = 4'b0010;
    tick(1);
    ext_irq = '0;
    tick(5);
    check("t6_edge_sticky", mip_ext, 4'b0010);
    check("t6_no_trap_mie0", trap, 0);
    csr(3'd3, 2'd1, 32'h8);
    tick(1);
    check("t6_trap", trap, 1);
    check("t6_mcause", mcause, 32'h8000_0011);
    check("t6_mip_cleared", mip_ext, 0);
    tick(1);
    irq_en = '0;
    ext_irq = 4'b0010;
    tick(1);
    ext_irq = '0;
    tick(5);
    check("t6_edge_again", mip_ext, 4'b0010);
    csr(3'd4, 2'd2, 32'h0002_0000);
    check("t6_csr_clear", mip_ext, 0);
`else
    // without edge support a short pulse on a line marked edge just passes through
    irq_edge_sel = 4'b0010; irq_en = '0;
    ext_irq = 4'b0010;
    tick(1);
    ext_irq = '0;
    tick(2);
    check("t6_level_pulse_seen", mip_ext, 4'b0010);
    tick(3);
    check("t6_level_pulse_gone", mip_ext, 0);
`endif

    // reset in the middle of a trap cycle
    exc_valid = 1'b1; exc_code = 4'd3;
    tick(1);
    exc_valid = 1'b0;
    check("rst_mid_trap_pre", trap, 1);
    cpu_rst = 1'b1;
    tick(1);
    check("rst_mid_trap", trap, 0);
    check("rst_mid_mcause", mcause, 32'hFFFF_FFFF);
    check("rst_mid_mepc", mepc, 0);
    check("rst_mid_status", {mstatus_mpie, mstatus_mie}, 0);
    cpu_rst = 1'b0;
    tick(2);
    check("post_rst_idle", trap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
